// File: rtl/tick_event_counter.sv
// tick_event_counter
//   Counts qualifying ticks from an upstream clock-divider stage into a
//   WIDTH-bit counter and flags the terminal-count event.
//
//   Optional build macro: TICK_EDGE_EN
//     defined   -> a tick qualifies only on a 0->1 transition of tick_in
//     undefined -> every cycle with tick_in=1 qualifies (level mode)
//
//   Parameters
//     WIDTH      counter width in bits
//     MAX_COUNT  terminal count value (<= 2^WIDTH-1)
//     WRAP       1: wrap to 0 and keep running, 0: hold at MAX_COUNT and stop
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous, active-high reset
//     tick_in     tick from upstream divider, synchronous to clk
//     en          count enable
//     clr         synchronous clear of count and sticky flag
//     count       current tick count
//     overflow    one-cycle pulse on the terminal event
//     ovf_sticky  set on overflow, cleared by clr or reset
//     running     high while the FSM is in RUN
//
//   state | meaning
//   IDLE  | counting disabled, count holds, waits for en
//   RUN   | counting qualifying ticks
//   STOP  | terminal count reached with WRAP=0, frozen until clr/reset

module tick_event_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter bit WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             overflow_nxt;
  logic             sticky_nxt;
  logic             tick_q;
  logic             qtick;

`ifdef TICK_EDGE_EN
  assign qtick = tick_in & ~tick_q;
`else
  assign qtick = tick_in;
  // History is still kept in level mode so both builds share one datapath.
  logic unused_tick_q;
  assign unused_tick_q = tick_q;
`endif

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    overflow_nxt = 1'b0;
    sticky_nxt   = ovf_sticky;

    if (clr) begin
      // clr outranks any coincident qtick: the tick is dropped.
      count_nxt  = '0;
      sticky_nxt = 1'b0;
      state_nxt  = en ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) state_nxt = RUN;
        end
        RUN: begin
          if (!en) begin
            state_nxt = IDLE;
          end else if (qtick) begin
            if (count != MAX_VAL) begin
              count_nxt = count + 1'b1;
            end else begin
              overflow_nxt = 1'b1;
              sticky_nxt   = 1'b1;
              if (WRAP) count_nxt = '0;
              else      state_nxt = STOP;
            end
          end
        end
        STOP: begin
          state_nxt = STOP;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      overflow   <= overflow_nxt;
      ovf_sticky <= sticky_nxt;
      tick_q     <= tick_in;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_tick_event_counter.sv
module tb_tick_event_counter;

  localparam int W   = 4;
  localparam int MAX = 15;

`ifdef TICK_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
  localparam int EXP_HELD  = 1;
`else
  localparam bit EDGE_MODE = 1'b0;
  localparam int EXP_HELD  = 4;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick_in = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] count_w, count_s;
  logic         ovf_w, ovf_s, stk_w, stk_s, run_w, run_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_event_counter #(.WIDTH(W), .MAX_COUNT(MAX), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .tick_in(tick_in), .en(en), .clr(clr),
    .count(count_w), .overflow(ovf_w), .ovf_sticky(stk_w), .running(run_w));

  tick_event_counter #(.WIDTH(W), .MAX_COUNT(MAX), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .tick_in(tick_in), .en(en), .clr(clr),
    .count(count_s), .overflow(ovf_s), .ovf_sticky(stk_s), .running(run_s));

  typedef struct {
    int cnt;
    bit ovf;
    bit sticky;
    int mode;
    bit prev;
  } mdl_t;

  mdl_t mw, ms;

  function automatic mdl_t mstep(mdl_t m, bit r, bit t, bit e, bit c, bit wrap);
    mdl_t n;
    bit   q;
    n = m;
    n.ovf = 1'b0;
    if (r) begin
      n.cnt = 0; n.sticky = 1'b0; n.mode = M_IDLE; n.prev = 1'b0;
      return n;
    end
    q = EDGE_MODE ? (t && !m.prev) : t;
    n.prev = t;
    if (c) begin
      n.cnt = 0; n.sticky = 1'b0;
      n.mode = e ? M_RUN : M_IDLE;
    end else if (m.mode == M_IDLE) begin
      if (e) n.mode = M_RUN;
    end else if (m.mode == M_RUN) begin
      if (!e) n.mode = M_IDLE;
      else if (q) begin
        if (m.cnt < MAX) n.cnt = m.cnt + 1;
        else begin
          n.ovf = 1'b1; n.sticky = 1'b1;
          if (wrap) n.cnt = 0;
          else      n.mode = M_STOP;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit e, input bit c);
    reset = r; tick_in = t; en = e; clr = c;
    @(posedge clk);
    #1;
    mw = mstep(mw, r, t, e, c, 1'b1);
    ms = mstep(ms, r, t, e, c, 1'b0);
    chk("mdl_w_count", int'(count_w), mw.cnt);
    chk("mdl_w_ovf", int'(ovf_w), int'(mw.ovf));
    chk("mdl_w_sticky", int'(stk_w), int'(mw.sticky));
    chk("mdl_w_running", int'(run_w), int'(mw.mode == M_RUN));
    chk("mdl_s_count", int'(count_s), ms.cnt);
    chk("mdl_s_ovf", int'(ovf_s), int'(ms.ovf));
    chk("mdl_s_sticky", int'(stk_s), int'(ms.sticky));
    chk("mdl_s_running", int'(run_s), int'(ms.mode == M_RUN));
  endtask

  // one single-cycle tick followed by two idle cycles (divide-by-3 shape)
  task automatic pulse(input bit e);
    cyc(1'b0, 1'b1, e, 1'b0);
    cyc(1'b0, 1'b0, e, 1'b0);
    cyc(1'b0, 1'b0, e, 1'b0);
  endtask

  typedef struct {
    bit r, t, e, c;
    int cnt;
    bit ovf, stk, run;
  } vec_t;

  initial begin
    vec_t vt[13];
    bit   seen;

    mw = '{0, 1'b0, 1'b0, M_IDLE, 1'b0};
    ms = mw;

    // Single-cycle ticks only, so both tick-qualification builds agree.
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].r, vt[i].t, vt[i].e, vt[i].c);
      chk($sformatf("vec%0d_count", i), int'(count_w), vt[i].cnt);
      chk($sformatf("vec%0d_ovf", i), int'(ovf_w), int'(vt[i].ovf));
      chk($sformatf("vec%0d_sticky", i), int'(stk_w), int'(vt[i].stk));
      chk($sformatf("vec%0d_running", i), int'(run_w), int'(vt[i].run));
    end

    // Reset held while tick toggles and en=1, then one cycle after.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, i[0], 1'b1, 1'b0);
      chk("rst_count", int'(count_w), 0);
      chk("rst_flags", int'({ovf_w, stk_w, run_w, run_s}), 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", int'(count_w), 0);
    chk("post_rst_flags", int'({ovf_w, stk_w, run_w}), 0);

    // Terminal behaviour, wrap and stop instances side by side.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pulse(1'b1);
      seen |= ovf_w | ovf_s;
    end
    chk("t15_count_w", int'(count_w), 15);
    chk("t15_count_s", int'(count_s), 15);
    chk("t15_no_ovf", int'(seen), 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t16_count_w", int'(count_w), 0);
    chk("t16_ovf_w", int'(ovf_w), 1);
    chk("t16_sticky_w", int'(stk_w), 1);
    chk("t16_running_w", int'(run_w), 1);
    chk("t16_count_s", int'(count_s), 15);
    chk("t16_ovf_s", int'(ovf_s), 1);
    chk("t16_running_s", int'(run_s), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t16_pulse_end", int'({ovf_w, ovf_s}), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t17_count_w", int'(count_w), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1);
      seen |= ovf_s;
    end
    chk("stop_count_s", int'(count_s), 15);
    chk("stop_no_ovf", int'(seen), 0);
    chk("stop_sticky_s", int'(stk_s), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_count_s", int'(count_s), 0);
    chk("clr_sticky_s", int'(stk_s), 0);
    chk("clr_running_s", int'(run_s), 1);
    chk("clr_sticky_w", int'(stk_w), 0);

    // clr coinciding with a tick at count 7.
    for (int i = 0; i < 7; i++) pulse(1'b1);
    chk("c7_count", int'(count_w), 7);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_tick_count", int'(count_w), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) pulse(1'b1);
    chk("r7_count", int'(count_s), 7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_tick_count", int'(count_w), 0);
    chk("rst_tick_flags", int'({ovf_w, stk_w, run_w}), 0);

    // Enable gating at count 5.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    chk("en5_count", int'(count_w), 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) pulse(1'b0);
    chk("en_off_count", int'(count_w), 5);
    chk("en_off_running", int'(run_w), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("en_on_count", int'(count_w), 6);

    // tick_in held high for four cycles.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("held_count", int'(count_w), EXP_HELD);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 2) == 0) || (tick_in && $urandom_range(0, 1) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_event_counter.md
Name: tick_event_counter

Overview:
Downstream consumer of the divide-by-N Moore FSM output (y of the divide-by-3 stage). Counts qualifying ticks on tick_in into a WIDTH-bit counter and flags terminal-count overflow. Supports enable, synchronous clear, and wrap or stop-at-terminal policy. Sits between the clock-divider FSM and any slow-event logic, such as a seconds or LED sequencer.

Parameters:
WIDTH, 4, counter width in bits.
MAX_COUNT, 15, terminal count value. Must be ≤ 2^WIDTH-1.
WRAP, 1, terminal behaviour. 1 = wrap to 0 and keep running. 0 = hold at MAX_COUNT and stop.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
tick_in  input  1  tick from upstream divider (y). Synchronous to clk.
en  input  1  count enable.
clr  input  1  synchronous clear of count and sticky flag.
count  output  WIDTH  current tick count.
overflow  output  1  one-cycle pulse on the terminal event.
ovf_sticky  output  1  set on overflow. Cleared only by clr or reset.
running  output  1  high when the FSM is in RUN.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset. All state updates on the rising edge of clk.
- Reset values:
  - count=0, overflow=0, ovf_sticky=0, running=0
  - FSM=IDLE
  - tick history register tick_q=0
  - Reset dominates every other input.
- Qualifying tick (qtick): see Optional Feature. tick_q <= tick_in every cycle except under reset, regardless of state.
- Latency: a qtick sampled at edge k is reflected in count / overflow immediately after edge k. No combinational path from tick_in to any output.
- FSM states: IDLE, RUN, STOP. 2-bit encoding.
  - IDLE: count holds, qticks ignored. en=1 -> RUN.
  - RUN:
    - en=0 -> IDLE, count holds.
    - qtick with count<MAX_COUNT -> count+1.
    - qtick with count==MAX_COUNT and WRAP=1 -> count=0, overflow=1 for one cycle, ovf_sticky=1, stay RUN.
    - qtick with count==MAX_COUNT and WRAP=0 -> count holds at MAX_COUNT, overflow=1 for one cycle, ovf_sticky=1, go to STOP.
  - STOP: count holds, qticks ignored, no further overflow pulses. en has no effect. Exit only via clr or reset.
- clr (when reset=0):
  - count=0, ovf_sticky=0, overflow=0.
  - Next state is RUN if en=1, else IDLE. This applies from any state.
- Priority: reset > clr > qtick. A qtick coinciding with clr is dropped (count=0, not 1).
- overflow is registered and never high for two consecutive cycles.
- Arithmetic: unsigned, modulo 2^WIDTH never reached, because the terminal compare is against MAX_COUNT.
- running = (state==RUN). It is registered and reflects the state after the edge.
- Reset mid-count forces all reset values on that edge. The first qtick after reset requires en=1 and, in edge mode, a fresh 0->1 transition.

Optional Feature:
Macro TICK_EDGE_EN.
- Defined: qtick = tick_in & ~tick_q (rising-edge detect). A tick_in level held high for many cycles counts once.
- Undefined: qtick = tick_in (level mode). Every cycle with tick_in=1 counts. tick_q is still present but unused by the count logic.
- Both builds have identical outputs for single-cycle tick pulses, such as the divide-by-3 pattern 1,0,0.

Test Plan:
1. Reset: hold reset=1 for 3 cycles while tick_in toggles and en=1, clr=0 -> count=0, overflow=0, ovf_sticky=0, running=0 during and 1 cycle after.
2. WRAP=1, MAX_COUNT=15, en=1, tick_in pattern 1,0,0 repeated.
   - After 15 ticks: count=15, overflow never seen.
   - 16th tick: count=0, overflow=1 for exactly one cycle, ovf_sticky=1, running=1.
   - 17th tick: count=1.
3. WRAP=0 build, 16 ticks -> count=15, one overflow pulse, running=0 (STOP).
   - 5 more ticks -> count stays 15, no pulse.
   - clr with en=1 -> count=0, ovf_sticky=0, running=1.
4. Simultaneity at count=7:
   - clr and qtick in the same cycle -> count=0.
   - Separately, reset asserted with qtick at count=7 -> all reset values.
5. Enable gating at count=5:
   - Drop en, apply 6 ticks -> count=5, running=0.
   - Raise en, then one tick -> count=6.
6. tick_in held high 4 consecutive cycles from count=0, en=1 -> count=1 with TICK_EDGE_EN, count=4 without.
